// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register indices, SR field layout,
// and the SR read-word packer.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic [31:0] sr_word(sr_t s);
    logic [31:0] w;
    w = '0;
    w[IM_HI:IM_LO] = s.im;
    w[EXL_BIT]     = s.exl;
    w[IE_BIT]      = s.ie;
    return w;
  endfunction

endpackage

// File: rtl/cp0_sync.sv
// Multi-stage flop chain with async clear, used to bring the
// external interrupt lines into the clock domain.
module cp0_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC, PRId and the interrupt request
// presented to the multi-cycle controller.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID        = 32'h0000_1921,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Sel,
  input  logic [31:0] DIn,
  input  logic        Wen,
  input  logic [29:0] PC,
  input  logic [5:0]  HWInt,
  input  logic        EXLSet,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [29:0] EPC,
  output logic [31:0] DOut
);

  sr_t         sr;
  logic [29:0] epc_q;
  logic [5:0]  ip;
  logic        wr_sr;
  logic        wr_epc;

  cp0_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (HWInt),
    .q   (ip)
  );

  assign wr_sr  = Wen && (Sel == CP0_SR);
  assign wr_epc = Wen && (Sel == CP0_EPC);

  // Hardware strobes outrank mtc0 on EXL and EPC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      epc_q <= '0;
    end else begin
      if (wr_sr) begin
        sr.im <= DIn[IM_HI:IM_LO];
        sr.ie <= DIn[IE_BIT];
      end
      if (EXLSet) begin
        sr.exl <= 1'b1;
      end else if (EXLClr) begin
        sr.exl <= 1'b0;
      end else if (wr_sr) begin
        sr.exl <= DIn[EXL_BIT];
      end
      if (EXLSet) begin
        epc_q <= PC;
      end else if (wr_epc) begin
        epc_q <= DIn[31:2];
      end
    end
  end

  assign EPC    = epc_q;
  assign IntReq = (|(ip & sr.im)) & sr.ie & ~sr.exl;

  always_comb begin
    DOut = '0;
    unique case (1'b1)
      (Sel == CP0_SR):    DOut = sr_word(sr);
      (Sel == CP0_CAUSE): DOut = {16'h0, ip, 10'h0};
      (Sel == CP0_EPC):   DOut = {epc_q, 2'b00};
      (Sel == CP0_PRID):  DOut = PRID;
      default:            DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_cp0_unit;

  localparam int          S      = 2;
  localparam logic [31:0] PRID_V = 32'h0000_1921;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Sel;
  logic [31:0] DIn;
  logic        Wen;
  logic [29:0] PC;
  logic [5:0]  HWInt;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  int vectors     = 0;
  int miscompares = 0;

  cp0_unit #(
    .PRID        (PRID_V),
    .SYNC_STAGES (S)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Sel    (Sel),
    .DIn    (DIn),
    .Wen    (Wen),
    .PC     (PC),
    .HWInt  (HWInt),
    .EXLSet (EXLSet),
    .EXLClr (EXLClr),
    .IntReq (IntReq),
    .EPC    (EPC),
    .DOut   (DOut)
  );

  always #5 clk = ~clk;

  // Reference model: architectural fields plus a history of HWInt samples.
  logic [5:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic [29:0] m_epc;
  logic [5:0]  m_hist[$];

  function automatic logic [5:0] m_ip();
    return (m_hist.size() >= S) ? m_hist[S-1] : 6'h0;
  endfunction

  function automatic logic m_irq();
    return (|(m_ip() & m_im)) & m_ie & ~m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {16'h0, m_ip(), 10'h0};
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return PRID_V;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_im  = '0;
    m_ie  = 1'b0;
    m_exl = 1'b0;
    m_epc = '0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    logic sr_w;
    if (rst) begin
      model_reset();
    end else begin
      m_hist.push_front(HWInt);
      if (m_hist.size() > S) void'(m_hist.pop_back());
      sr_w = Wen && (Sel == 5'd12);
      if (sr_w) begin
        m_im = DIn[15:10];
        m_ie = DIn[0];
      end
      if (EXLSet)      m_exl = 1'b1;
      else if (EXLClr) m_exl = 1'b0;
      else if (sr_w)   m_exl = DIn[1];
      if (EXLSet)                        m_epc = PC;
      else if (Wen && (Sel == 5'd14))    m_epc = DIn[31:2];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    Wen    = 1'b0;
    EXLSet = 1'b0;
    EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b1; Sel = '0; DIn = '0; PC = '0; HWInt = '0;
    idle();
    step(); step();
    rst = 1'b0;
    Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_FC01; HWInt = 6'h3F;
    step();
    Wen = 1'b0;
    step(); step();
    vectors++;
    if (IntReq !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_irq: got %b expected 1", IntReq);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (IntReq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", IntReq);
    end
    for (int s = 12; s <= 15; s++) begin
      Sel = 5'(s);
      #1;
      exp = (s == 15) ? PRID_V : 32'h0;
      vectors++;
      if (DOut !== exp) begin
        miscompares++;
        $display("FAIL reset_read%0d: got %h expected %h", s, DOut, exp);
      end
    end
    HWInt = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_unmask();
    Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_FC01;
    step();
    Wen = 1'b0;
    HWInt = 6'b000100;
    step();
    vectors++;
    if (IntReq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_edge1: got %b expected 0", IntReq);
    end
    step();
    vectors++;
    if (IntReq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_edge2: got %b expected 1", IntReq);
    end
    Sel = 5'd13;
    #1;
    vectors++;
    if (DOut !== 32'h0000_1000) begin
      miscompares++;
      $display("FAIL cause_ip: got %h expected 00001000", DOut);
    end
  endtask

  task automatic test_entry_exit();
    EXLSet = 1'b1; PC = 30'h0000_0C04;
    step();
    EXLSet = 1'b0;
    vectors++;
    if (IntReq !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_irq: got %b expected 0", IntReq);
    end
    Sel = 5'd14;
    #1;
    vectors++;
    if (DOut !== 32'h0000_3010 || EPC !== 30'h0000_0C04) begin
      miscompares++;
      $display("FAIL entry_epc: got %h/%h expected 00003010/0000c04",
               DOut, EPC);
    end
    Sel = 5'd12;
    #1;
    vectors++;
    if (DOut !== 32'h0000_FC03) begin
      miscompares++;
      $display("FAIL entry_sr: got %h expected 0000fc03", DOut);
    end
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    vectors++;
    if (IntReq !== 1'b1) begin
      miscompares++;
      $display("FAIL eret_irq: got %b expected 1", IntReq);
    end
  endtask

  task automatic test_masking();
    Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_0001; HWInt = 6'h3F;
    step();
    Wen = 1'b0;
    repeat (3) begin
      step();
      vectors++;
      if (IntReq !== 1'b0) begin
        miscompares++;
        $display("FAIL mask_im: got %b expected 0", IntReq);
      end
    end
    Wen = 1'b1; DIn = 32'h0000_0400;
    step();
    Wen = 1'b0;
    repeat (3) begin
      step();
      vectors++;
      if (IntReq !== 1'b0) begin
        miscompares++;
        $display("FAIL mask_ie: got %b expected 0", IntReq);
      end
    end
  endtask

  task automatic test_collisions();
    Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_FC01;
    step();
    Wen = 1'b0;
    EXLSet = 1'b1; EXLClr = 1'b1;
    step();
    idle();
    #1;
    vectors++;
    if (DOut !== 32'h0000_FC03 || IntReq !== 1'b0) begin
      miscompares++;
      $display("FAIL set_clr: got %h/%b expected 0000fc03/0", DOut, IntReq);
    end
    EXLSet = 1'b1; Wen = 1'b1; Sel = 5'd14;
    DIn = 32'hDEAD_BEEF; PC = 30'h0000_0C04;
    step();
    idle();
    vectors++;
    if (DOut !== 32'h0000_3010) begin
      miscompares++;
      $display("FAIL set_mtc0_epc: got %h expected 00003010", DOut);
    end
    EXLSet = 1'b1; Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_FC01;
    step();
    idle();
    vectors++;
    if (DOut !== 32'h0000_FC03) begin
      miscompares++;
      $display("FAIL set_mtc0_sr: got %h expected 0000fc03", DOut);
    end
    EXLClr = 1'b1; Wen = 1'b1; DIn = 32'h0000_FC03;
    step();
    idle();
    vectors++;
    if (DOut !== 32'h0000_FC01 || IntReq !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_mtc0_sr: got %h/%b expected 0000fc01/1",
               DOut, IntReq);
    end
  endtask

  task automatic test_read_only();
    Wen = 1'b1; Sel = 5'd13; DIn = 32'hFFFF_FFFF;
    step();
    Wen = 1'b0;
    vectors++;
    if (DOut !== 32'h0000_FC00) begin
      miscompares++;
      $display("FAIL cause_ro: got %h expected 0000fc00", DOut);
    end
    Wen = 1'b1; Sel = 5'd15; DIn = 32'h0;
    step();
    Wen = 1'b0;
    vectors++;
    if (DOut !== PRID_V) begin
      miscompares++;
      $display("FAIL prid_ro: got %h expected %h", DOut, PRID_V);
    end
    Wen = 1'b1; Sel = 5'd7; DIn = 32'hFFFF_FFFF;
    step();
    Wen = 1'b0;
    vectors++;
    if (DOut !== 32'h0) begin
      miscompares++;
      $display("FAIL reg7_ro: got %h expected 00000000", DOut);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int n = 0; n < 600; n++) begin
      rst = 1'b0;
      case ($urandom_range(0, 5))
        0:       Sel = 5'd7;
        1, 2:    Sel = 5'd12;
        3:       Sel = 5'd13;
        4:       Sel = 5'd14;
        default: Sel = 5'($urandom_range(0, 31));
      endcase
      Wen    = ($urandom_range(0, 9) < 3);
      EXLSet = ($urandom_range(0, 9) == 0);
      EXLClr = ($urandom_range(0, 9) == 0);
      DIn    = $urandom;
      PC     = 30'($urandom);
      if ($urandom_range(0, 4) == 0) HWInt = 6'($urandom);
      step();
      idle();
      exp = m_read(Sel);
      vectors++;
      if (DOut !== exp || IntReq !== m_irq() || EPC !== m_epc) begin
        miscompares++;
        $display("FAIL rand[%0d] sel%0d: got %h/%b/%h expected %h/%b/%h",
                 n, Sel, DOut, IntReq, EPC, exp, m_irq(), m_epc);
      end
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (IntReq !== 1'b0 || DOut !== m_read(Sel)) begin
          miscompares++;
          $display("FAIL rand_reset[%0d]: got %b/%h expected 0/%h",
                   n, IntReq, DOut, m_read(Sel));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_unmask();
    test_entry_exit();
    test_masking();
    test_collisions();
    test_read_only();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
